// File: rtl/adc_channel_averager.sv
// Multi-channel moving-average filter: per-channel circular window + running sum, 3-stage pipeline.
// Optional build macro ADC_AVERAGER_FILL_GATE_EN suppresses out_valid until a channel's window fills.
module adc_channel_averager #(
  parameter int unsigned N_CHANNELS   = 4,
  parameter int unsigned SAMPLE_WIDTH = 12,
  parameter int unsigned LOG2_DEPTH   = 8
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               in_valid,
  input  logic [$clog2(N_CHANNELS > 1 ? N_CHANNELS : 2)-1:0] in_channel,
  input  logic [SAMPLE_WIDTH-1:0]                            in_sample,
  output logic                                               in_ready,
  input  logic                                               hold,
  output logic                                               out_valid,
  output logic [$clog2(N_CHANNELS > 1 ? N_CHANNELS : 2)-1:0] out_channel,
  output logic [SAMPLE_WIDTH-1:0]                            out_average,
  output logic [N_CHANNELS-1:0]                              out_filled
);

  localparam int unsigned CHW    = $clog2(N_CHANNELS > 1 ? N_CHANNELS : 2);
  localparam int unsigned DEPTH  = 2 ** LOG2_DEPTH;
  localparam int unsigned SUMW   = SAMPLE_WIDTH + LOG2_DEPTH;
  localparam int unsigned AW     = CHW + LOG2_DEPTH;
  localparam int unsigned FW     = LOG2_DEPTH + 1;
  localparam int unsigned NWORDS = N_CHANNELS * DEPTH;

  typedef enum logic {StInit, StRun} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           init_addr_q, init_addr_d;
  logic [SAMPLE_WIDTH-1:0] mem_q [NWORDS];

  logic [LOG2_DEPTH-1:0]   ptr_q  [N_CHANNELS];
  logic [LOG2_DEPTH-1:0]   ptr_d  [N_CHANNELS];
  logic [SUMW-1:0]         sum_q  [N_CHANNELS];
  logic [SUMW-1:0]         sum_d  [N_CHANNELS];
  logic [FW-1:0]           fill_q [N_CHANNELS];
  logic [FW-1:0]           fill_d [N_CHANNELS];

  // S0 (combinational read with forwarding)
  logic                    accept, fwd;
  logic [LOG2_DEPTH-1:0]   s0_ptr;
  logic [SUMW-1:0]         s0_sum;
  logic [SAMPLE_WIDTH-1:0] s0_old;

  // S1 registers
  logic                    s1_valid_q, s1_valid_d;
  logic [CHW-1:0]          s1_ch_q, s1_ch_d;
  logic [SAMPLE_WIDTH-1:0] s1_new_q, s1_new_d;
  logic [SAMPLE_WIDTH-1:0] s1_old_q, s1_old_d;
  logic [LOG2_DEPTH-1:0]   s1_ptr_q, s1_ptr_d;
  logic [SUMW-1:0]         s1_sum_q, s1_sum_d;
  logic [SUMW-1:0]         s1_sum_new;
  logic [FW-1:0]           s1_fill_new;

  // S2 registers
  logic                    s2_valid_q, s2_valid_d;
  logic [CHW-1:0]          s2_ch_q, s2_ch_d;
  logic [SAMPLE_WIDTH-1:0] s2_avg_q, s2_avg_d;
`ifdef ADC_AVERAGER_FILL_GATE_EN
  logic                    s2_filled_q, s2_filled_d;
`endif

  logic                    report;
  logic                    out_valid_q, out_valid_d;
  logic [CHW-1:0]          out_channel_q, out_channel_d;
  logic [SAMPLE_WIDTH-1:0] out_average_q, out_average_d;

  logic                    mem_we;
  logic [AW-1:0]           mem_waddr;
  logic [SAMPLE_WIDTH-1:0] mem_wdata;

  assign in_ready    = (state_q == StRun);
  assign out_valid   = out_valid_q;
  assign out_channel = out_channel_q;
  assign out_average = out_average_q;

  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      out_filled[c] = (fill_q[c] == FW'(DEPTH));
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      StInit: begin
        init_addr_d = init_addr_q + AW'(1);
        if (init_addr_q == AW'(NWORDS - 1)) begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // A same-channel sample in S1 has not yet committed its pointer/sum; take them from S1.
  always_comb begin
    accept = in_valid && (state_q == StRun) && (32'(in_channel) < N_CHANNELS);
    fwd    = s1_valid_q && (s1_ch_q == in_channel);
    s0_ptr = fwd ? s1_ptr_q + LOG2_DEPTH'(1) : ptr_q[in_channel];
    s0_sum = fwd ? s1_sum_new : sum_q[in_channel];
    s0_old = (fwd && (s0_ptr == s1_ptr_q)) ? s1_new_q : mem_q[{in_channel, s0_ptr}];
  end

  always_comb begin
    s1_valid_d = accept;
    s1_ch_d    = in_channel;
    s1_new_d   = in_sample;
    s1_old_d   = s0_old;
    s1_ptr_d   = s0_ptr;
    s1_sum_d   = s0_sum;
  end

  // The oldest sample is always part of the sum, so the subtraction cannot underflow.
  always_comb begin
    s1_sum_new  = s1_sum_q - SUMW'(s1_old_q) + SUMW'(s1_new_q);
    s1_fill_new = (fill_q[s1_ch_q] == FW'(DEPTH)) ? fill_q[s1_ch_q]
                                                  : fill_q[s1_ch_q] + FW'(1);
    ptr_d  = ptr_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    if (s1_valid_q) begin
      ptr_d[s1_ch_q]  = s1_ptr_q + LOG2_DEPTH'(1);
      sum_d[s1_ch_q]  = s1_sum_new;
      fill_d[s1_ch_q] = s1_fill_new;
    end
  end

  always_comb begin
    mem_we    = (state_q == StInit) || s1_valid_q;
    mem_waddr = (state_q == StInit) ? init_addr_q : {s1_ch_q, s1_ptr_q};
    mem_wdata = (state_q == StInit) ? '0 : s1_new_q;
  end

  always_comb begin
    s2_valid_d  = s1_valid_q;
    s2_ch_d     = s1_ch_q;
    s2_avg_d    = s1_sum_new[SUMW-1 -: SAMPLE_WIDTH];
`ifdef ADC_AVERAGER_FILL_GATE_EN
    s2_filled_d = (s1_fill_new == FW'(DEPTH));
    report      = s2_valid_q && s2_filled_q && !hold;
`else
    report      = s2_valid_q && !hold;
`endif
    out_valid_d   = report;
    out_channel_d = report ? s2_ch_q : out_channel_q;
    out_average_d = report ? s2_avg_q : out_average_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StInit;
      init_addr_q   <= '0;
      ptr_q         <= '{default: '0};
      sum_q         <= '{default: '0};
      fill_q        <= '{default: '0};
      s1_valid_q    <= 1'b0;
      s1_ch_q       <= '0;
      s1_new_q      <= '0;
      s1_old_q      <= '0;
      s1_ptr_q      <= '0;
      s1_sum_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_ch_q       <= '0;
      s2_avg_q      <= '0;
`ifdef ADC_AVERAGER_FILL_GATE_EN
      s2_filled_q   <= 1'b0;
`endif
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_average_q <= '0;
    end else begin
      state_q       <= state_d;
      init_addr_q   <= init_addr_d;
      ptr_q         <= ptr_d;
      sum_q         <= sum_d;
      fill_q        <= fill_d;
      s1_valid_q    <= s1_valid_d;
      s1_ch_q       <= s1_ch_d;
      s1_new_q      <= s1_new_d;
      s1_old_q      <= s1_old_d;
      s1_ptr_q      <= s1_ptr_d;
      s1_sum_q      <= s1_sum_d;
      s2_valid_q    <= s2_valid_d;
      s2_ch_q       <= s2_ch_d;
      s2_avg_q      <= s2_avg_d;
`ifdef ADC_AVERAGER_FILL_GATE_EN
      s2_filled_q   <= s2_filled_d;
`endif
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      out_average_q <= out_average_d;
    end
  end

endmodule

// File: tb/tb_adc_channel_averager.sv
// Directed bench for adc_channel_averager (2 channels, depth 4, 12-bit samples).
module tb_adc_channel_averager;

  localparam int unsigned NCH = 2;
  localparam int unsigned SW  = 12;
  localparam int unsigned L2D = 2;
`ifdef ADC_AVERAGER_FILL_GATE_EN
  localparam bit Gate = 1'b1;
`else
  localparam bit Gate = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset, in_valid, hold;
  logic [0:0]     in_channel;
  logic [SW-1:0]  in_sample;
  logic           in_ready, out_valid;
  logic [0:0]     out_channel;
  logic [SW-1:0]  out_average;
  logic [NCH-1:0] out_filled;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int ev_cyc[$], ev_ch[$], ev_avg[$];
  int e_cyc[$], e_ch[$], e_avg[$];

  adc_channel_averager #(
    .N_CHANNELS  (NCH),
    .SAMPLE_WIDTH(SW),
    .LOG2_DEPTH  (L2D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_channel (in_channel),
    .in_sample  (in_sample),
    .in_ready   (in_ready),
    .hold       (hold),
    .out_valid  (out_valid),
    .out_channel(out_channel),
    .out_average(out_average),
    .out_filled (out_filled)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (out_valid === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_ch.push_back(int'(out_channel));
      ev_avg.push_back(int'(out_average));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int ch, input int s, output int acc);
    in_valid   = 1'b1;
    in_channel = ch[0:0];
    in_sample  = s[SW-1:0];
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  task automatic clear_q();
    ev_cyc.delete(); ev_ch.delete(); ev_avg.delete();
    e_cyc.delete();  e_ch.delete();  e_avg.delete();
  endtask

  // Queue an expected output; skipped when the fill gate would suppress it.
  task automatic expect_out(input int ch, input int avg, input int acc, input int fill);
    if (!Gate || fill >= 4) begin
      e_ch.push_back(ch);
      e_avg.push_back(avg);
      e_cyc.push_back(acc + 2);
    end
  endtask

  task automatic do_reset();
    int n;
    reset = 1'b1; in_valid = 1'b0; hold = 1'b0;
    idle(2);
    reset = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      idle(1);
      n++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL do_reset ready: got %b, expected 1", in_ready);
    end
    clear_q();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; hold = 1'b0; in_channel = '0; in_sample = '0;
    idle(2);
    vectors += 5;
    if (in_ready !== 1'b0)    begin errors++; $display("FAIL rst in_ready: got %b, expected 0", in_ready); end
    if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst out_valid: got %b, expected 0", out_valid); end
    if (out_average !== '0)   begin errors++; $display("FAIL rst out_average: got %0d, expected 0", out_average); end
    if (out_channel !== '0)   begin errors++; $display("FAIL rst out_channel: got %0d, expected 0", out_channel); end
    if (out_filled !== 2'b00) begin errors++; $display("FAIL rst out_filled: got %b, expected 00", out_filled); end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL init ready[%0d]: got %b, expected 0", i, in_ready);
      end
      idle(1);
    end
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL init done: got %b, expected 1", in_ready); end
    clear_q();
  endtask

  task automatic test_ramp();
    int smp[4] = '{100, 200, 300, 400};
    int avg[4] = '{25, 75, 150, 250};
    int acc;
    clear_q();
    for (int i = 0; i < 4; i++) begin
      send(0, smp[i], acc);
      expect_out(0, avg[i], acc, i + 1);
    end
    idle(4);
    vectors++;
    if (ev_avg.size() != e_avg.size()) begin
      errors++; $display("FAIL ramp count: got %0d, expected %0d", ev_avg.size(), e_avg.size());
    end
    for (int i = 0; i < e_avg.size() && i < ev_avg.size(); i++) begin
      vectors++;
      if (ev_avg[i] != e_avg[i] || ev_ch[i] != e_ch[i] || ev_cyc[i] != e_cyc[i]) begin
        errors++;
        $display("FAIL ramp[%0d]: got ch%0d avg %0d cyc %0d, expected ch%0d avg %0d cyc %0d",
                 i, ev_ch[i], ev_avg[i], ev_cyc[i], e_ch[i], e_avg[i], e_cyc[i]);
      end
    end
    vectors++;
    if (out_filled !== 2'b01) begin errors++; $display("FAIL ramp filled: got %b, expected 01", out_filled); end
  endtask

  task automatic test_back_to_back();
    int smp[6] = '{4095, 4095, 4095, 4095, 0, 0};
    int avg[6] = '{1023, 2047, 3071, 4095, 3071, 2047};
    int acc;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(0, smp[i], acc);
      expect_out(0, avg[i], acc, i + 1);
    end
    idle(4);
    vectors++;
    if (ev_avg.size() != e_avg.size()) begin
      errors++; $display("FAIL b2b count: got %0d, expected %0d", ev_avg.size(), e_avg.size());
    end
    for (int i = 0; i < e_avg.size() && i < ev_avg.size(); i++) begin
      vectors++;
      if (ev_avg[i] != e_avg[i] || ev_ch[i] != e_ch[i] || ev_cyc[i] != e_cyc[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: got ch%0d avg %0d cyc %0d, expected ch%0d avg %0d cyc %0d",
                 i, ev_ch[i], ev_avg[i], ev_cyc[i], e_ch[i], e_avg[i], e_cyc[i]);
      end
    end
  endtask

  task automatic test_interleave();
    int avg0[4] = '{10, 20, 30, 40};
    int avg1[4] = '{20, 40, 60, 80};
    int acc;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        send(0, 40, acc);
        expect_out(0, avg0[i/2], acc, i/2 + 1);
      end else begin
        send(1, 80, acc);
        expect_out(1, avg1[i/2], acc, i/2 + 1);
      end
    end
    idle(4);
    vectors++;
    if (ev_avg.size() != e_avg.size()) begin
      errors++; $display("FAIL ilv count: got %0d, expected %0d", ev_avg.size(), e_avg.size());
    end
    for (int i = 0; i < e_avg.size() && i < ev_avg.size(); i++) begin
      vectors++;
      if (ev_avg[i] != e_avg[i] || ev_ch[i] != e_ch[i] || ev_cyc[i] != e_cyc[i]) begin
        errors++;
        $display("FAIL ilv[%0d]: got ch%0d avg %0d cyc %0d, expected ch%0d avg %0d cyc %0d",
                 i, ev_ch[i], ev_avg[i], ev_cyc[i], e_ch[i], e_avg[i], e_cyc[i]);
      end
    end
    vectors++;
    if (out_filled !== 2'b11) begin errors++; $display("FAIL ilv filled: got %b, expected 11", out_filled); end
  endtask

  task automatic test_hold();
    int acc;
    do_reset();
    for (int i = 0; i < 4; i++) send(1, 400, acc);
    idle(4);
    vectors++;
    if (ev_avg.size() == 0 || ev_avg[ev_avg.size()-1] != 400) begin
      errors++;
      $display("FAIL hold pre: got %0d events, expected last avg 400", ev_avg.size());
    end
    clear_q();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) send(0, 800, acc);
    idle(4);
    vectors += 3;
    if (ev_avg.size() != 0)   begin errors++; $display("FAIL hold pulses: got %0d, expected 0", ev_avg.size()); end
    if (out_average !== 400)  begin errors++; $display("FAIL hold avg: got %0d, expected 400", out_average); end
    if (out_channel !== 1'b1) begin errors++; $display("FAIL hold ch: got %0d, expected 1", out_channel); end
    hold = 1'b0;
    send(0, 800, acc);
    idle(4);
    vectors++;
    if (ev_avg.size() != 1 || ev_avg[0] != 800 || ev_ch[0] != 0 || ev_cyc[0] != acc + 2) begin
      errors++;
      $display("FAIL hold release: got %0d events, expected one ch0 avg 800 at cyc %0d",
               ev_avg.size(), acc + 2);
    end
  endtask

  task automatic test_fill_gate_and_reset();
    int avg[4] = '{2, 4, 6, 8};
    int acc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(1, 8, acc);
      expect_out(1, avg[i], acc, i + 1);
    end
    idle(4);
    vectors++;
    if (ev_avg.size() != e_avg.size()) begin
      errors++; $display("FAIL gate count: got %0d, expected %0d", ev_avg.size(), e_avg.size());
    end
    for (int i = 0; i < e_avg.size() && i < ev_avg.size(); i++) begin
      vectors++;
      if (ev_avg[i] != e_avg[i] || ev_ch[i] != e_ch[i] || ev_cyc[i] != e_cyc[i]) begin
        errors++;
        $display("FAIL gate[%0d]: got ch%0d avg %0d cyc %0d, expected ch%0d avg %0d cyc %0d",
                 i, ev_ch[i], ev_avg[i], ev_cyc[i], e_ch[i], e_avg[i], e_cyc[i]);
      end
    end
    vectors++;
    if (out_filled !== 2'b10) begin errors++; $display("FAIL gate filled: got %b, expected 10", out_filled); end
    clear_q();
    // Reset with a sample in flight and another offered alongside reset: both dropped.
    send(0, 50, acc);
    reset = 1'b1; in_valid = 1'b1; in_channel = 1'b0; in_sample = 12'd77;
    idle(2);
    vectors += 3;
    if (out_valid !== 1'b0)   begin errors++; $display("FAIL mid rst valid: got %b, expected 0", out_valid); end
    if (out_filled !== 2'b00) begin errors++; $display("FAIL mid rst filled: got %b, expected 00", out_filled); end
    if (in_ready !== 1'b0)    begin errors++; $display("FAIL mid rst ready: got %b, expected 0", in_ready); end
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL reinit ready[%0d]: got %b, expected 0", i, in_ready);
      end
      idle(1);
    end
    vectors += 2;
    if (in_ready !== 1'b1)    begin errors++; $display("FAIL reinit done: got %b, expected 1", in_ready); end
    if (ev_avg.size() != 0)   begin errors++; $display("FAIL reinit pulses: got %0d, expected 0", ev_avg.size()); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_back_to_back();
    test_interleave();
    test_hold();
    test_fill_gate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
